// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a circular FIFO,
// serialised LSB-first at CLK_HZ/BAUD with back-to-back frames when data is queued.
module uart_tx_fifo #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     uart_TXD,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_s;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] baud_r;
  logic [CW-1:0] baud_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          txd_r;
  logic          txd_s;
  logic          ready_r;
  logic          busy_r;
  logic          push_s;
  logic          pop_s;
  logic          tick_s;

  assign push_s     = tx_valid && ready_r;
  assign tick_s     = (baud_r == BAUD_LAST);
  assign tx_ready   = ready_r;
  assign uart_TXD   = txd_r;
  assign busy       = busy_r;
  assign fifo_level = level_r;

  // Frame sequencer: next state, baud/bit counters, shift register, FIFO pop and line level.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    txd_s   = 1'b1;
    case (state_r)
      IDLE: begin
        txd_s = 1'b1;
        if (level_r != LVL_ZERO) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          baud_s  = BAUD_ZERO;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        txd_s = 1'b0;
        if (tick_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      DATA: begin
        txd_s = shift_r[0];
        if (tick_s) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      STOP: begin
        txd_s = 1'b1;
        if (tick_s) begin
          baud_s = BAUD_ZERO;
          // Chain straight into the next start bit when more data is queued.
          if (level_r != LVL_ZERO) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        txd_s   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    level_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_ONE;
      2'b01:   level_s = level_r - LVL_ONE;
      default: level_s = level_r;
    endcase
  end

  // FIFO storage; contents are invalidated by pointer reset, so no reset here.
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r  <= IDLE;
      baud_r   <= BAUD_ZERO;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      txd_r    <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      level_r <= level_s;
      txd_r   <= txd_s;
      ready_r <= (level_s != LVL_FULL);
      busy_r  <= (state_s != IDLE) || (level_s != LVL_ZERO);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: literal checks on a default-rate instance plus a
// frame-level reference model and serial decoder on a fast-baud instance.
module tb_uart_tx_fifo;

  localparam int DIV_A   = 434;
  localparam int DIV_B   = 10;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       ready_a, txd_a, busy_a;
  logic       ready_b, txd_b, busy_b;
  logic [4:0] level_a, level_b;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo u_dut_a (
    .clk_clk(clk), .reset_reset(rst_a), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .uart_TXD(txd_a), .busy(busy_a), .fifo_level(level_a)
  );

  uart_tx_fifo #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(DEPTH_B)) u_dut_b (
    .clk_clk(clk), .reset_reset(rst_b), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .uart_TXD(txd_b), .busy(busy_b), .fifo_level(level_b)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level model of instance B: queue of held bytes plus position within the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_active = 1'b0;
  int         m_ph = 0;
  int         m_pre, m_bit;
  bit         m_push;
  logic       e_txd = 1'b1, e_ready = 1'b1, e_busy = 1'b0;
  int         e_level = 0;

  initial forever begin
    @(posedge clk);
    if (rst_b) begin
      m_q.delete();
      m_active = 1'b0;
      m_ph = 0;
      e_txd = 1'b1; e_level = 0; e_ready = 1'b1; e_busy = 1'b0;
    end else begin
      m_pre  = m_q.size();
      m_push = valid_b && (m_pre != DEPTH_B);
      m_bit  = m_ph / DIV_B;
      if (!m_active)        e_txd = 1'b1;
      else if (m_bit == 0)  e_txd = 1'b0;
      else if (m_bit <= 8)  e_txd = m_cur[m_bit-1];
      else                  e_txd = 1'b1;
      if (m_active && m_ph != 10*DIV_B-1) begin
        m_ph++;
      end else if (m_pre > 0) begin
        m_cur = m_q.pop_front();
        m_active = 1'b1;
        m_ph = 0;
      end else begin
        m_active = 1'b0;
      end
      if (m_push) m_q.push_back(data_b);
      e_level = m_q.size();
      e_ready = (e_level != DEPTH_B);
      e_busy  = m_active || (e_level != 0);
    end
  end

  // Per-cycle compare of instance B against the model.
  int max_lvl = 0;
  bit ready_low_seen = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_b) begin
      check("b_txd",   txd_b,   e_txd);
      check("b_level", level_b, e_level);
      check("b_ready", ready_b, e_ready);
      check("b_busy",  busy_b,  e_busy);
      if (e_level > max_lvl) max_lvl = e_level;
      if (!e_ready) ready_low_seen = 1'b1;
    end
  end

  // Serial decoder on instance B's line, sampling mid-bit.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = 8'h00;
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  int         rx_k;
  initial forever begin
    @(negedge clk);
    if (rst_b) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (txd_b == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV_B == DIV_B / 2) begin
        rx_k = rx_cnt / DIV_B;
        if (rx_k == 0) begin
          check("b_start_bit", txd_b, 1'b0);
        end else if (rx_k <= 8) begin
          rx_sh[rx_k-1] = txd_b;
        end else begin
          check("b_stop_bit", txd_b, 1'b1);
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  task automatic push_list(output int cycles);
    int g;
    cycles = 0;
    foreach (stim_q[i]) begin
      valid_b = 1'b1;
      data_b  = stim_q[i];
      g = 0;
      while (!ready_b && g < 2000) begin
        @(posedge clk); #1;
        g++;
        cycles++;
      end
      if (g >= 2000) check("push_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      cycles++;
    end
    valid_b = 1'b0;
  endtask

  task automatic wait_idle_b(string name);
    int g;
    g = 0;
    while (busy_b !== 1'b0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check(name, (g < 5000), 1'b1);
    repeat (2*DIV_B) @(negedge clk);
  endtask

  task automatic check_rx(string name);
    check(name, rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) check(name, rx_q[i], exp_q[i]);
    end
    rx_q.delete();
  endtask

  int cyc;

  initial begin
    // Instance A: idle after reset, then one 0x55 frame at 434 clocks per bit.
    @(posedge clk); #3 rst_a = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      check("a_idle_txd", txd_a, 1'b1);
      check("a_idle_ready", ready_a, 1'b1);
      check("a_idle_busy", busy_a, 1'b0);
      check("a_idle_level", level_a, 5'd0);
    end
    valid_a = 1'b1; data_a = 8'h55;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    check("a_level_after_accept", level_a, 5'd1);
    check("a_txd_after_accept", txd_a, 1'b1);
    @(negedge clk);
    check("a_txd_after_pop", txd_a, 1'b1);
    check("a_level_after_pop", level_a, 5'd0);
    check("a_busy_after_pop", busy_a, 1'b1);
    for (int i = 0; i < 10*DIV_A; i++) begin
      @(negedge clk);
      check("a_frame_txd", txd_a, ((i / DIV_A) % 2 == 1) ? 1'b1 : 1'b0);
      if (i == 10*DIV_A-2) check("a_busy_before_end", busy_a, 1'b1);
      if (i == 10*DIV_A-1) check("a_busy_at_end", busy_a, 1'b0);
    end
    @(negedge clk);
    check("a_txd_after_frame", txd_a, 1'b1);
    check("a_busy_after_frame", busy_a, 1'b0);

    // Instance B: burst with tx_valid held high.
    @(posedge clk); #3 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    max_lvl = 0;
    stim_q.delete(); stim_q.push_back(8'h00); stim_q.push_back(8'hFF); stim_q.push_back(8'hA3);
    exp_q = stim_q;
    @(posedge clk); #1;
    push_list(cyc);
    check("burst_cycles", cyc, 32'd3);
    wait_idle_b("burst_idle");
    check("burst_peak", max_lvl, 32'd2);
    check_rx("burst_rx");

    // Fill past DEPTH: 20 bytes, pointer wrap.
    max_lvl = 0; ready_low_seen = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 20; i++) stim_q.push_back(8'((i * 37 + 5) % 256));
    exp_q = stim_q;
    push_list(cyc);
    wait_idle_b("fill_idle");
    check("fill_peak", max_lvl, 32'd16);
    check("fill_ready_dropped", ready_low_seen, 1'b1);
    check_rx("fill_rx");

    // Push and pop on the same edge at the end of a stop bit with level 5.
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(8'(8'h10 + i));
    exp_q = stim_q;
    exp_q.push_back(8'hC6);
    push_list(cyc);
    check("pp_cycles", cyc, 32'd6);
    repeat (95) @(posedge clk);
    #1;
    check("pp_level_before", level_b, 5'd5);
    valid_b = 1'b1; data_b = 8'hC6;
    @(posedge clk); #1;
    valid_b = 1'b0;
    check("pp_level_after", level_b, 5'd5);
    wait_idle_b("pp_idle");
    check_rx("pp_rx");

    // Asynchronous reset in the middle of a data bit of 0x00.
    stim_q.delete(); stim_q.push_back(8'h00); stim_q.push_back(8'h11);
    push_list(cyc);
    repeat (35) @(posedge clk);
    #2;
    check("rst_pre_txd", txd_b, 1'b0);
    check("rst_pre_level", level_b, 5'd1);
    rst_b = 1'b1;
    #1;
    check("rst_txd", txd_b, 1'b1);
    check("rst_level", level_b, 5'd0);
    check("rst_ready", ready_b, 1'b1);
    check("rst_busy", busy_b, 1'b0);
    @(posedge clk); #3 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete();
    stim_q.delete(); stim_q.push_back(8'h5A);
    exp_q = stim_q;
    @(posedge clk); #1;
    push_list(cyc);
    wait_idle_b("post_rst_idle");
    check_rx("post_rst_rx");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
